// File: rtl/axi_stream_packet_receiver.sv
// AXI4-Stream packet receiver.
// Buffers incoming beats in a small FIFO and replays them to a downstream consumer.
// Measures the byte length of each packet from tkeep, counts completed packets,
// and keeps sticky flags for upstream protocol violations.
module axi_stream_packet_receiver #(
  parameter int BYTE_WIDTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    tvalid,
  input  logic [8*BYTE_WIDTH-1:0] tdata,
  input  logic [BYTE_WIDTH-1:0]   tstrb,
  input  logic [BYTE_WIDTH-1:0]   tkeep,
  input  logic                    tlast,
  output logic                    tready,
  output logic                    out_valid,
  output logic [8*BYTE_WIDTH-1:0] out_data,
  output logic [BYTE_WIDTH-1:0]   out_keep,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    pkt_done,
  output logic [LEN_WIDTH-1:0]    pkt_bytes,
  output logic                    pkt_ovf,
  output logic [LEN_WIDTH-1:0]    pkt_count,
  input  logic                    err_clear,
  output logic                    err_strb,
  output logic                    err_drop,
  output logic                    err_unstable
);

  localparam int DATA_W  = 8 * BYTE_WIDTH;
  localparam int ENTRY_W = DATA_W + BYTE_WIDTH + 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W   = PTR_W + 1;
  localparam int PC_W    = $clog2(BYTE_WIDTH + 1);
  // The sum carries one bit above the wider of the length field and the
  // per-beat byte count, so saturation is visible even for tiny LEN_WIDTH.
  localparam int SUM_W   = ((LEN_WIDTH > PC_W) ? LEN_WIDTH : PC_W) + 1;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [SUM_W-1:0] LEN_MAX  = SUM_W'({LEN_WIDTH{1'b1}});

  // Receive buffer
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occupancy;
  logic               ready_en;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Packet statistics
  logic [LEN_WIDTH-1:0] acc;
  logic                 ovf;
  logic [SUM_W-1:0]     keep_cnt;
  logic [SUM_W-1:0]     acc_sum;
  logic                 acc_sat;
  logic [LEN_WIDTH-1:0] acc_next;

  // Protocol checking
  logic                 stall_q;
  logic [DATA_W-1:0]    tdata_q;
  logic [BYTE_WIDTH-1:0] tstrb_q;
  logic [BYTE_WIDTH-1:0] tkeep_q;
  logic                 tlast_q;
  logic                 strb_det;
  logic                 drop_det;
  logic                 unstable_det;

  assign fifo_full  = (occupancy == OCC_FULL);
  assign fifo_empty = (occupancy == '0);

  // tready depends only on flops, so the upstream master sees no input-to-output path.
  assign tready    = ready_en & ~fifo_full;
  assign push      = tvalid & tready;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_keep  = out_valid ? head[DATA_W +: BYTE_WIDTH] : '0;
  assign out_last  = out_valid ? head[ENTRY_W-1] : 1'b0;

  // Enable acceptance one edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Buffer storage; contents are don't-care while empty, outputs are gated above.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= {tlast, tkeep, tdata};
    end
  end

  // Pointers and occupancy; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Byte count of the current beat and the saturated running total.
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < BYTE_WIDTH; i++) begin
      keep_cnt = keep_cnt + SUM_W'(tkeep[i]);
    end
    acc_sum  = SUM_W'(acc) + keep_cnt;
    acc_sat  = (acc_sum > LEN_MAX);
    acc_next = acc_sat ? {LEN_WIDTH{1'b1}} : acc_sum[LEN_WIDTH-1:0];
  end

  // Packet statistics follow upstream transfers only, never downstream pops.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc       <= '0;
      ovf       <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_bytes <= '0;
      pkt_ovf   <= 1'b0;
      pkt_count <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (push) begin
        if (tlast) begin
          pkt_bytes <= acc_next;
          pkt_ovf   <= ovf | acc_sat;
          pkt_done  <= 1'b1;
          pkt_count <= pkt_count + LEN_WIDTH'(1);
          acc       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= acc_next;
          ovf <= ovf | acc_sat;
        end
      end
    end
  end

  // A stall is a beat offered while the buffer is full after enable;
  // the master must then hold the beat unchanged until it is taken.
  assign strb_det     = tvalid & (|(tstrb & ~tkeep));
  assign drop_det     = stall_q & ~tvalid;
  assign unstable_det = stall_q & ((tdata != tdata_q) | (tstrb != tstrb_q) |
                                   (tkeep != tkeep_q) | (tlast != tlast_q));

  // Remember the previous cycle's offer for the stability checks.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_q <= 1'b0;
      tdata_q <= '0;
      tstrb_q <= '0;
      tkeep_q <= '0;
      tlast_q <= 1'b0;
    end else begin
      stall_q <= tvalid & ~tready & ready_en;
      tdata_q <= tdata;
      tstrb_q <= tstrb;
      tkeep_q <= tkeep;
      tlast_q <= tlast;
    end
  end

  // Sticky error flags; a fresh detection takes priority over err_clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_strb     <= 1'b0;
      err_drop     <= 1'b0;
      err_unstable <= 1'b0;
    end else begin
      if (strb_det) begin
        err_strb <= 1'b1;
      end else if (err_clear) begin
        err_strb <= 1'b0;
      end
      if (drop_det) begin
        err_drop <= 1'b1;
      end else if (err_clear) begin
        err_drop <= 1'b0;
      end
      if (unstable_det) begin
        err_unstable <= 1'b1;
      end else if (err_clear) begin
        err_unstable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_packet_receiver.sv
// Bench for axi_stream_packet_receiver: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_axi_stream_packet_receiver;

  localparam int BW   = 4;
  localparam int FD   = 4;
  localparam int LW   = 4;
  localparam int LMAX = (1 << LW) - 1;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          tvalid = 1'b0;
  logic [8*BW-1:0] tdata = '0;
  logic [BW-1:0] tstrb = '0;
  logic [BW-1:0] tkeep = '0;
  logic          tlast = 1'b0;
  logic          tready;
  logic          out_valid;
  logic [8*BW-1:0] out_data;
  logic [BW-1:0] out_keep;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          pkt_done;
  logic [LW-1:0] pkt_bytes;
  logic          pkt_ovf;
  logic [LW-1:0] pkt_count;
  logic          err_clear = 1'b0;
  logic          err_strb;
  logic          err_drop;
  logic          err_unstable;

  int n_checks = 0;
  int n_fail   = 0;

  axi_stream_packet_receiver #(.BYTE_WIDTH(BW), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .tvalid(tvalid), .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast),
    .tready(tready),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_ready(out_ready),
    .pkt_done(pkt_done), .pkt_bytes(pkt_bytes), .pkt_ovf(pkt_ovf), .pkt_count(pkt_count),
    .err_clear(err_clear), .err_strb(err_strb), .err_drop(err_drop), .err_unstable(err_unstable)
  );

  always #5 aclk = ~aclk;

  // Reference model state
  typedef struct {
    logic [8*BW-1:0] data;
    logic [BW-1:0]   keep;
    logic            last;
  } beat_t;

  beat_t q[$];
  bit    m_ready_en;
  int    m_acc;
  bit    m_ovf;
  bit    m_pkt_done;
  int    m_pkt_bytes;
  bit    m_pkt_ovf;
  int    m_pkt_count;
  bit    m_err_strb, m_err_drop, m_err_unst;
  bit    p_stall;
  logic [8*BW-1:0] p_data;
  logic [BW-1:0]   p_strb, p_keep;
  logic            p_last;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ready_en  = 0;
    m_acc       = 0;
    m_ovf       = 0;
    m_pkt_done  = 0;
    m_pkt_bytes = 0;
    m_pkt_ovf   = 0;
    m_pkt_count = 0;
    m_err_strb  = 0;
    m_err_drop  = 0;
    m_err_unst  = 0;
    p_stall     = 0;
    p_data      = '0;
    p_strb      = '0;
    p_keep      = '0;
    p_last      = 1'b0;
  endtask

  task automatic model_step();
    bit rdy, xfer, pop, sat, d_strb, d_drop, d_unst;
    int s;
    beat_t b;
    rdy    = m_ready_en && (q.size() < FD);
    xfer   = tvalid && rdy;
    pop    = (q.size() > 0) && out_ready;
    d_strb = tvalid && ((tstrb & ~tkeep) != 0);
    d_drop = p_stall && !tvalid;
    d_unst = p_stall && (tdata != p_data || tstrb != p_strb || tkeep != p_keep || tlast != p_last);
    m_pkt_done = 0;
    if (xfer) begin
      s   = m_acc + $countones(tkeep);
      sat = (s > LMAX);
      if (sat) s = LMAX;
      if (tlast) begin
        m_pkt_bytes = s;
        m_pkt_ovf   = m_ovf | sat;
        m_pkt_done  = 1;
        m_pkt_count = (m_pkt_count + 1) % (LMAX + 1);
        m_acc       = 0;
        m_ovf       = 0;
      end else begin
        m_acc = s;
        m_ovf = m_ovf | sat;
      end
    end
    if (pop) q.delete(0);
    if (xfer) begin
      b.data = tdata;
      b.keep = tkeep;
      b.last = tlast;
      q.push_back(b);
    end
    m_err_strb = d_strb ? 1'b1 : (err_clear ? 1'b0 : m_err_strb);
    m_err_drop = d_drop ? 1'b1 : (err_clear ? 1'b0 : m_err_drop);
    m_err_unst = d_unst ? 1'b1 : (err_clear ? 1'b0 : m_err_unst);
    p_stall    = tvalid && !rdy && m_ready_en;
    p_data     = tdata;
    p_strb     = tstrb;
    p_keep     = tkeep;
    p_last     = tlast;
    m_ready_en = 1;
  endtask

  task automatic compare_all();
    logic [8*BW-1:0] e_data;
    logic [BW-1:0]   e_keep;
    logic            e_last;
    e_data = '0;
    e_keep = '0;
    e_last = 1'b0;
    if (q.size() > 0) begin
      e_data = q[0].data;
      e_keep = q[0].keep;
      e_last = q[0].last;
    end
    check_val("tready",       tready,       m_ready_en && (q.size() < FD));
    check_val("out_valid",    out_valid,    q.size() > 0);
    check_val("out_data",     out_data,     e_data);
    check_val("out_keep",     out_keep,     e_keep);
    check_val("out_last",     out_last,     e_last);
    check_val("pkt_done",     pkt_done,     m_pkt_done);
    check_val("pkt_bytes",    pkt_bytes,    m_pkt_bytes);
    check_val("pkt_ovf",      pkt_ovf,      m_pkt_ovf);
    check_val("pkt_count",    pkt_count,    m_pkt_count);
    check_val("err_strb",     err_strb,     m_err_strb);
    check_val("err_drop",     err_drop,     m_err_drop);
    check_val("err_unstable", err_unstable, m_err_unst);
  endtask

  // One clock: inputs are already driven (at the falling edge); check, advance model, step.
  task automatic cycle();
    #1;
    if (!aresetn) model_reset();
    compare_all();
    if (aresetn) model_step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                       input logic [3:0] s, input logic l);
    tvalid = v;
    tdata  = d;
    tkeep  = k;
    tstrb  = s;
    tlast  = l;
  endtask

  initial begin
    model_reset();
    @(negedge aclk);
    cycle();
    cycle();

    // Reset release: tready low until the first edge, then high
    aresetn = 1'b1;
    check_val("rel_tready_c0", tready, 1'b0);
    cycle();
    check_val("rel_tready_c1", tready, 1'b1);
    check_val("rel_out_valid", out_valid, 1'b0);
    check_val("rel_flags", {err_strb, err_drop, err_unstable}, 3'b000);
    cycle();

    // Three-beat packet of 4+4+2 bytes
    out_ready = 1'b1;
    drive(1, 32'h11111111, 4'hF, 4'hF, 0); cycle();
    drive(1, 32'h22222222, 4'hF, 4'hF, 0); cycle();
    drive(1, 32'h33333333, 4'h3, 4'h3, 1); cycle();
    check_val("p3_done", pkt_done, 1'b1);
    check_val("p3_bytes", pkt_bytes, 10);
    check_val("p3_ovf", pkt_ovf, 1'b0);
    check_val("p3_count", pkt_count, 1);
    drive(0, 0, 4'h0, 4'h0, 0); cycle();
    check_val("p3_done_pulse", pkt_done, 1'b0);
    cycle();

    // Length saturation: 20 bytes into a 4-bit length, then a 1-byte packet
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h40000000 + i, 4'hF, 4'hF, i == 4);
      cycle();
    end
    check_val("sat_bytes", pkt_bytes, 15);
    check_val("sat_ovf", pkt_ovf, 1'b1);
    drive(1, 32'h50000000, 4'h1, 4'h1, 1); cycle();
    check_val("one_bytes", pkt_bytes, 1);
    check_val("one_ovf", pkt_ovf, 1'b0);
    drive(0, 0, 4'h0, 4'h0, 0); cycle(); cycle();

    // Fill with consumer stalled; exactly FD beats taken
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'hC0000000 + ((i < 4) ? i : 4), 4'hF, 4'hF, i >= 4);
      cycle();
    end
    check_val("full_tready", tready, 1'b0);
    check_val("full_head", out_data, 32'hC0000000);
    out_ready = 1'b1; cycle();
    out_ready = 1'b0;
    check_val("after_pop_tready", tready, 1'b1);
    cycle();
    drive(0, 0, 4'h0, 4'h0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check_val("fill_no_err", {err_strb, err_drop, err_unstable}, 3'b000);

    // Protocol errors while stalled on a full buffer
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hD0000000 + i, 4'hF, 4'hF, 1);
      cycle();
    end
    drive(1, 32'hA5A5A5A5, 4'hF, 4'hF, 0); cycle();
    drive(1, 32'h00000000, 4'hF, 4'hF, 0); cycle();
    check_val("unstable_set", err_unstable, 1'b1);
    cycle();
    drive(0, 32'h00000000, 4'hF, 4'hF, 0); cycle();
    check_val("drop_set", err_drop, 1'b1);
    drive(1, 32'h00000000, 4'h1, 4'h3, 0); cycle();
    check_val("strb_set", err_strb, 1'b1);
    out_ready = 1'b1; cycle();
    out_ready = 1'b0; cycle();
    drive(0, 0, 4'h0, 4'h0, 0);
    err_clear = 1'b1; cycle();
    err_clear = 1'b0;
    check_val("clear_flags", {err_strb, err_drop, err_unstable}, 3'b000);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Reset in the middle of a packet
    out_ready = 1'b0;
    drive(1, 32'hE0000000, 4'hF, 4'hF, 0); cycle();
    drive(1, 32'hE0000001, 4'hF, 4'hF, 0); cycle();
    drive(0, 0, 4'h0, 4'h0, 0);
    aresetn = 1'b0; cycle();
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_pkt_count", pkt_count, 0);
    cycle();
    aresetn = 1'b1; cycle(); cycle();
    check_val("rst_no_done", pkt_done, 1'b0);
    out_ready = 1'b1;
    drive(1, 32'hF0000000, 4'hF, 4'hF, 1); cycle();
    check_val("post_rst_bytes", pkt_bytes, 4);
    check_val("post_rst_count", pkt_count, 1);
    drive(0, 0, 4'h0, 4'h0, 0); cycle();

    // Random traffic, including protocol violations, clears and occasional resets
    for (int n = 0; n < 3000; n++) begin
      aresetn = ($urandom_range(0, 399) != 0);
      if (!(tvalid && m_ready_en && q.size() >= FD && $urandom_range(0, 5) != 0)) begin
        tvalid = ($urandom_range(0, 3) != 0);
        tdata  = $urandom;
        tkeep  = 4'($urandom_range(0, 15));
        tstrb  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : tkeep;
        tlast  = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      err_clear = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_packet_receiver.md
AXI_STREAM_PACKET_RECEIVER -- requirements
Module: axi_stream_packet_receiver

Interface
REQ-001 Parameter BYTE_WIDTH, default 4, TDATA width in bytes; SHALL be 1..64.
REQ-002 Parameter FIFO_DEPTH, default 4, entries of receive buffering; SHALL be a power of two, at least 2.
REQ-003 Parameter LEN_WIDTH, default 16, width of packet byte length and packet count.
REQ-004 aclk  in  1  sole clock; all state SHALL update on rising edge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low; release is sampled on aclk.
REQ-006 tvalid, tdata[8*BYTE_WIDTH], tstrb[BYTE_WIDTH], tkeep[BYTE_WIDTH], tlast  in  AXI4-Stream slave inputs from the upstream master.
REQ-007 tready  out  1  AXI4-Stream slave ready.
REQ-008 out_valid, out_data[8*BYTE_WIDTH], out_keep[BYTE_WIDTH], out_last  out  head-of-buffer beat to the downstream consumer.
REQ-009 out_ready  in  1  consumer accepts the head beat.
REQ-010 pkt_done  out  1  one-cycle pulse on completion of a packet.
REQ-011 pkt_bytes[LEN_WIDTH], pkt_ovf  out  byte length of the completed packet and its saturation flag; held until the next pkt_done.
REQ-012 pkt_count[LEN_WIDTH]  out  number of completed packets.
REQ-013 err_clear  in  1  clears the sticky error flags.
REQ-014 err_strb, err_drop, err_unstable  out  1 each  sticky protocol error flags.

Function
REQ-015 An upstream transfer SHALL occur when tvalid and tready are both high; on each transfer the SHALL write {tdata, tkeep, tlast} to the FIFO tail.
REQ-016 tready SHALL be driven from registers only, with no combinational path from any input.
REQ-017 tready SHALL be high exactly when ready_en is high and the FIFO holds fewer than FIFO_DEPTH entries; ready_en is a register set to 1 on the first aclk edge after aresetn is high.
REQ-018 out_valid SHALL equal FIFO non-empty; out_data, out_keep and out_last SHALL show the head entry; a pop SHALL occur when out_valid and out_ready are both high.
REQ-019 A simultaneous push and pop SHALL leave the occupancy unchanged; both pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 When the FIFO is full, tready is low and no push SHALL occur, even if a pop happens in the same cycle.
REQ-021 Byte accumulator: on each transfer, acc SHALL increase by popcount(tkeep); the sum saturates at 2^LEN_WIDTH-1 and sets an internal ovf bit.
REQ-022 On a transfer with tlast=1, the block SHALL:
  - set pkt_bytes to acc + popcount(tkeep), saturated;
  - set pkt_ovf to the ovf bit, including overflow caused by this beat;
  - assert pkt_done for exactly one cycle;
  - increment pkt_count, wrapping modulo 2^LEN_WIDTH;
  - clear acc and ovf to 0.
REQ-023 Statistics SHALL reflect upstream transfers and SHALL be independent of downstream back-pressure.
REQ-024 err_strb SHALL be set when tvalid is high and (tstrb & ~tkeep) is nonzero.
REQ-025 err_drop SHALL be set when the previous cycle had tvalid=1 and tready=0 with ready_en=1, and the current cycle has tvalid=0.
REQ-026 err_unstable SHALL be set when the previous cycle had tvalid=1 and tready=0 with ready_en=1, and any of tdata, tstrb, tkeep or tlast differs in the current cycle.
REQ-027 Error flags SHALL be sticky; err_clear SHALL clear them, and a new error detected in the same cycle as err_clear SHALL win.
REQ-028 A beat with tkeep=0 SHALL be accepted and stored and SHALL add 0 bytes to the accumulator.

Reset
REQ-029 While aresetn is low, the following SHALL all be 0: tready, ready_en, out_valid, pkt_done, pkt_bytes, pkt_ovf, pkt_count, acc, FIFO pointers and occupancy, and all error flags. out_data, out_keep and out_last SHALL be 0 while empty.
REQ-030 Reset asserted mid-packet SHALL discard the FIFO contents and the partial acc; no pkt_done SHALL be produced for the aborted packet.
REQ-031 In the first cycle after aresetn rises, tready SHALL remain 0; it SHALL be 1 from the second edge if the FIFO is not full.

Verification
REQ-032 Scenario: release reset, then hold tvalid=0 -> tready=0 for 1 cycle, then 1; out_valid=0; all flags 0.
REQ-033 Scenario: BYTE_WIDTH=4; send 3-beat packet with tkeep 0xF, 0xF, 0x3 (tlast on beat 3); out_ready=1 -> pkt_done one cycle after beat 3 with pkt_bytes=10, pkt_ovf=0, pkt_count=1; out_* replays the 3 beats in order.
REQ-034 Scenario: FIFO_DEPTH=4, out_ready=0, tvalid=1 continuously -> exactly 4 beats accepted; tready=0 afterwards; raise out_ready for 1 cycle -> one pop, then tready returns to 1 on the next cycle; no beat is lost or duplicated.
REQ-035 Scenario: LEN_WIDTH=4; 5 beats of tkeep=0xF with tlast on beat 5 -> pkt_bytes=15, pkt_ovf=1; next 1-beat packet with tkeep=0x1 -> pkt_bytes=1, pkt_ovf=0.
REQ-036 Scenario: FIFO full, tvalid=1 with tdata=0xA5A5A5A5; next cycle tdata=0x0 -> err_unstable=1. Separately, tvalid drops with tready=0 -> err_drop=1. tvalid=1 with tkeep=0x1, tstrb=0x3 -> err_strb=1. err_clear pulse -> all flags 0.
REQ-037 Scenario: assert reset after 2 beats of an unfinished packet -> out_valid=0 and pkt_count unchanged at 0; a subsequent 1-beat packet with tkeep=0xF -> pkt_bytes=4.
